seq_add_sub: RTL

Multi-cycle, chunked add/subtract unit that computes `op1 + op2` or `op1 - op2` as `op1 + ~op2 + 1`, one CHUNK_WIDTH slice per clock, with a registered carry between slices. It trades latency for a narrow carry chain, so wide operands (32–128 bit) close timing where a single-cycle adder does not. It sits between a valid/ready producer and consumer, and adds a signed-overflow flag to the widened `{cout,sum}` result.

---
 rtl/seq_add_sub.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle chunked add/subtract with valid/ready handshake.
// One CHUNK_WIDTH slice per clock, registered carry, signed-overflow flag.
module seq_add_sub #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   result,
    output logic                  overflow
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = CHUNK_WIDTH;

    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2x;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_carry;
    logic                  r_ovf;
    logic [IW-1:0]         r_idx;

    logic [CW-1:0]         w_a;
    logic [CW-1:0]         w_b;
    logic [CW:0]           w_add;
    logic                  w_cmsb;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_ins;

    // Operands shift down so the active chunk always sits at bit 0.
    assign w_a    = r_op1[CW-1:0];
    assign w_b    = r_op2x[CW-1:0];
    assign w_add  = {1'b0, w_a} + {1'b0, w_b} + {{CW{1'b0}}, r_carry};
    assign w_last = (r_idx == LAST_IDX);
    assign w_ins  = DATA_WIDTH'(w_add[CW-1:0]) << (DATA_WIDTH - CW);

    // Carry into the sum MSB, taken from the last chunk's low bits.
    generate
        if (CW == 1) begin : g_cmsb_bit
            assign w_cmsb = r_carry;
        end else begin : g_cmsb_low
            logic [CW-1:0] w_low;
            assign w_low  = {1'b0, w_a[CW-2:0]} + {1'b0, w_b[CW-2:0]}
                          + {{(CW-1){1'b0}}, r_carry};
            assign w_cmsb = w_low[CW-1];
        end
    endgenerate

    // Handshake flags decode straight from the state register.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = {r_carry, r_sum};
    assign overflow  = r_ovf;

    // Control FSM and chunk datapath; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op1   <= '0;
            r_op2x  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op1   <= op1;
                        r_op2x  <= op2 ^ {DATA_WIDTH{ctrl}};
                        r_carry <= ctrl;
                        r_idx   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_op1   <= r_op1 >> CW;
                    r_op2x  <= r_op2x >> CW;
                    r_sum   <= (r_sum >> CW) | w_ins;
                    r_carry <= w_add[CW];
                    if (w_last) begin
                        r_ovf   <= w_add[CW] ^ w_cmsb;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
